// File: rtl/pser_pkg.sv
// Shared types and defaults for the parity serializer.
//   state_t     : serializer FSM states (IDLE, SHIFT)
//   PSER_PAR_W  : default parity vector width in bits
//   PSER_OUT_W  : default output word width in bits
package pser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int unsigned PSER_PAR_W = 1024;
   localparam int unsigned PSER_OUT_W = 8;

endpackage : pser_pkg

// File: rtl/pser_beat_cnt.sv
// Beat counter for the parity serializer: counts transferred words of the
// current vector and flags the final beat.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to 0 (new vector, end of vector, abort)
//   inc      : one word transferred (ignored on the final beat)
//   last     : registered flag, count == NUM_WORDS-1
module pser_beat_cnt #(
   parameter int unsigned NUM_WORDS = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam int unsigned CNT_W = $clog2(NUM_WORDS);

   logic [CNT_W-1:0] count;

   // last is precomputed from the value being left so it aligns with count
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
         last  <= 1'b0;
      end else if (inc && !last) begin
         count <= count + CNT_W'(1);
         last  <= (count == CNT_W'(NUM_WORDS - 2));
      end
   end

endmodule : pser_beat_cnt

// File: rtl/parity_serializer.sv
// Parity serializer: captures a PAR_W-bit parity vector in one transfer and
// streams it as PAR_W/OUT_W words over a valid/ready handshake, with
// back-to-back reload on the final beat.
//   clk, rst                        : clock, synchronous active-high reset
//   abort                           : flush the vector in flight (no done)
//   load_valid/load_ready/load_data : vector input handshake
//   out_valid/out_ready/out_data    : word output handshake
//   out_last                        : current word is the final word
//   busy                            : vector in flight
//   done                            : one-cycle pulse after the final word
// Build option: define PSER_MSB_FIRST_EN to stream the most significant
// word first (bit order inside each word unchanged).
module parity_serializer
   import pser_pkg::*;
#(
   parameter int unsigned PAR_W = PSER_PAR_W,
   parameter int unsigned OUT_W = PSER_OUT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [PAR_W-1:0] load_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned NUM_WORDS = PAR_W / OUT_W;

   // parameter legality
   if ((PAR_W % OUT_W) != 0) begin : g_bad_width
      $error("parity_serializer: PAR_W must be a multiple of OUT_W");
   end
   if (NUM_WORDS < 2) begin : g_bad_words
      $error("parity_serializer: PAR_W/OUT_W must be at least 2");
   end

   state_t           state_q, state_d;
   logic [PAR_W-1:0] shift_q, shift_d, shift_next;
   logic             valid_q;
   logic             done_q, done_d;
   logic             cnt_clr, cnt_inc, cnt_last;
   logic             out_fire, final_fire, load_fire;

   // handshake decode; load_ready is the combinational back-to-back path
   assign out_fire   = valid_q && out_ready;
   assign final_fire = out_fire && cnt_last;
   assign load_ready = (state_q == IDLE) || final_fire;
   assign load_fire  = load_valid && load_ready;

`ifdef PSER_MSB_FIRST_EN
   assign shift_next = shift_q << OUT_W;
   assign out_data   = shift_q[PAR_W-1 -: OUT_W];
`else
   assign shift_next = shift_q >> OUT_W;
   assign out_data   = shift_q[OUT_W-1:0];
`endif

   assign out_valid = valid_q;
   assign busy      = valid_q;
   assign out_last  = cnt_last;
   assign done      = done_q;

   pser_beat_cnt #(
      .NUM_WORDS (NUM_WORDS)
   ) u_beat_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .last (cnt_last)
   );

   // state, shift register and registered status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         valid_q <= (state_d == SHIFT);
         done_q  <= done_d;
      end
   end

   // next state; abort outranks every fire
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      done_d  = 1'b0;

      if (abort) begin
         state_d = IDLE;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_fire) begin
                  shift_d = load_data;
                  cnt_clr = 1'b1;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (final_fire) begin
                  done_d  = 1'b1;
                  cnt_clr = 1'b1;
                  if (load_fire) begin
                     shift_d = load_data;
                  end else begin
                     shift_d = shift_next;
                     state_d = IDLE;
                  end
               end else if (out_fire) begin
                  shift_d = shift_next;
                  cnt_inc = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

endmodule : parity_serializer

// File: tb/tb_parity_serializer.sv
// Self-checking bench for parity_serializer (default 1024-bit / 8-bit build).
module tb_parity_serializer;

   localparam int PAR_W = 1024;
   localparam int OUT_W = 8;
   localparam int N     = PAR_W / OUT_W;

   logic             clk = 1'b0;
   logic             rst, abort, load_valid, load_ready, out_valid, out_ready;
   logic             out_last, busy, done;
   logic [PAR_W-1:0] load_data;
   logic [OUT_W-1:0] out_data;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   parity_serializer #(.PAR_W(PAR_W), .OUT_W(OUT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .abort      (abort),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [OUT_W-1:0] word_of(input logic [PAR_W-1:0] v, input int idx);
`ifdef PSER_MSB_FIRST_EN
      return v[PAR_W - (idx + 1) * OUT_W +: OUT_W];
`else
      return v[idx * OUT_W +: OUT_W];
`endif
   endfunction

   function automatic logic [PAR_W-1:0] rand_vec();
      logic [PAR_W-1:0] v;
      for (int i = 0; i < PAR_W / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // ---------------- behavioural model: vector + word index ----------------
   bit               m_live  = 1'b0;
   bit               m_busy  = 1'b0;
   bit               m_done  = 1'b0;
   bit               m_clean = 1'b0;
   int               m_idx   = 0;
   logic [PAR_W-1:0] m_vec   = '0;
   logic             m_ofire, m_final, m_lready;

   assign m_ofire  = m_busy && out_ready;
   assign m_final  = m_ofire && (m_idx == N - 1);
   assign m_lready = !m_busy || m_final;

   always @(posedge clk) begin
      if (rst) begin
         m_live  <= 1'b1;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_clean <= 1'b1;
         m_idx   <= 0;
      end else begin
         m_done <= m_final && !abort;
         if (abort) begin
            m_busy <= 1'b0;
            m_idx  <= 0;
         end else if (m_busy) begin
            if (m_final) begin
               m_idx <= 0;
               if (load_valid) m_vec  <= load_data;
               else            m_busy <= 1'b0;
            end else if (m_ofire) begin
               m_idx <= m_idx + 1;
            end
         end else if (load_valid) begin
            m_vec   <= load_data;
            m_idx   <= 0;
            m_busy  <= 1'b1;
            m_clean <= 1'b0;
         end
      end
   end

   // compare process: every cycle once the model has seen a reset
   always @(negedge clk) begin
      if (m_live) begin
         check("out_valid", 64'(out_valid), 64'(m_busy));
         check("busy", 64'(busy), 64'(m_busy));
         check("out_last", 64'(out_last), 64'(m_busy && (m_idx == N - 1)));
         check("done", 64'(done), 64'(m_done));
         check("load_ready", 64'(load_ready), 64'(m_lready));
         if (m_busy)       check("out_data", 64'(out_data), 64'(word_of(m_vec, m_idx)));
         else if (m_clean) check("out_data_rst", 64'(out_data), 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus with literal pins ----------------
   initial begin : stim
      logic [PAR_W-1:0] a_vec, b_vec, c_vec, d_vec;
      logic [7:0]       got[$];
      int               guard;

      rst = 1'b1; abort = 1'b0; load_valid = 1'b0; out_ready = 1'b0; load_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_load_ready", 64'(load_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);

      // directed: A5 / 3C, last on beat 127, done in cycle 129
      a_vec = rand_vec();
      a_vec[15:0] = 16'h3CA5;
      load_data = a_vec; load_valid = 1'b1; out_ready = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int n = 1; n <= 130; n++) begin
         if (n == 1) check("t1_word0", 64'(out_data), 64'hA5);
         if (n == 2) check("t1_word1", 64'(out_data), 64'h3C);
         check("t1_last", 64'(out_last), 64'(n == 128));
         check("t1_done", 64'(done), 64'(n == 129));
         tick();
      end

      // random backpressure, counting pattern
      for (int i = 0; i < N; i++) a_vec[i*8 +: 8] = 8'(i);
      load_data = a_vec; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      guard = 0;
      while (m_busy && guard < 3000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) got.push_back(out_data);
         tick();
         guard++;
      end
      check("bp_idle", 64'(busy), 64'd0);
      check("bp_count", 64'(got.size()), 64'(N));
      for (int i = 0; i < got.size() && i < N; i++) check("bp_word", 64'(got[i]), 64'(i));

      // back-to-back with load_valid held
      a_vec = rand_vec(); b_vec = rand_vec();
      load_data = a_vec; load_valid = 1'b1; out_ready = 1'b1;
      tick();
      load_data = b_vec;
      for (int n = 1; n <= 260; n++) begin
         if (n == 129) load_valid = 1'b0;
         check("b2b_valid", 64'(out_valid), 64'(n <= 256));
         check("b2b_done", 64'(done), 64'((n == 129) || (n == 257)));
         if (n == 1)   check("b2b_a0", 64'(out_data), 64'(a_vec[7:0]));
         if (n == 128) check("b2b_a127", 64'(out_data), 64'(a_vec[1023:1016]));
         if (n == 129) check("b2b_b0", 64'(out_data), 64'(b_vec[7:0]));
         tick();
      end

      // abort at beat 40 with a competing load
      c_vec = rand_vec(); d_vec = rand_vec();
      load_data = c_vec; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      repeat (40) tick();
      check("ab_word40", 64'(out_data), 64'(c_vec[327:320]));
      abort = 1'b1; load_valid = 1'b1; load_data = d_vec;
      tick();
      abort = 1'b0; load_valid = 1'b0;
      for (int n = 0; n < 5; n++) begin
         check("ab_valid", 64'(out_valid), 64'd0);
         check("ab_done", 64'(done), 64'd0);
         tick();
      end
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      check("ab_new_word0", 64'(out_data), 64'(d_vec[7:0]));
      guard = 0;
      while (m_busy && guard < 300) begin tick(); guard++; end

      // reset at beat 60
      a_vec = rand_vec();
      load_data = a_vec; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      repeat (60) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_valid", 64'(out_valid), 64'd0);
      check("rs_last", 64'(out_last), 64'd0);
      check("rs_busy", 64'(busy), 64'd0);
      check("rs_done", 64'(done), 64'd0);
      check("rs_data", 64'(out_data), 64'd0);
      check("rs_ready", 64'(load_ready), 64'd1);

      // random mix against the model
      for (int c = 0; c < 4000; c++) begin
         rst        = ($urandom_range(0, 499) == 0);
         abort      = ($urandom_range(0, 59) == 0);
         load_valid = ($urandom_range(0, 2) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         load_data  = rand_vec();
         tick();
      end
      rst = 1'b0; abort = 1'b0; load_valid = 1'b0; out_ready = 1'b1;
      repeat (N + 4) tick();
      check("end_idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_parity_serializer
